ahb_spi_accel: RTL

AHB_SPI_ACCEL -- requirements
Module: ahb_spi_accel

---
 rtl/ahb_spi_accel_if.sv | 23 ++
 rtl/ahb_spi_accel.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ahb_spi_accel_if.sv
// AHB-Lite slave bus bundle for the SPI accelerometer bridge.
// The master side drives address/control/write data; the slave returns read data.
interface ahb_spi_accel_if;
    logic        HSEL;
    logic        HREADY;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;

    modport master (
        output HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
        input  HRDATA, HREADYOUT
    );

    modport slave (
        input  HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
        output HRDATA, HREADYOUT
    );
endinterface

// File: rtl/ahb_spi_accel.sv
// AHB-Lite to SPI mode-0 byte shifter for an accelerometer.
// Software owns chip select; each TXDATA write shifts one byte out and in.
module ahb_spi_accel #(
    parameter int DIV = 25
) (
    input  logic          HCLK,
    input  logic          HRESET,
    ahb_spi_accel_if.slave bus,
    output logic          SCLK,
    output logic          MOSI,
    input  logic          MISO,
    output logic          CSn
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_t;

    localparam logic [7:0] LAST = 8'(DIV - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] bitcnt;
    logic [7:0] shreg;
    logic [7:0] rxdata;
    logic       busy;
    logic       rxvalid;
    logic       cs_en;

    logic       pend;
    logic       pend_wr;
    logic [1:0] pend_addr;

    logic       wr_tx;
    logic       wr_ctrl;
    logic       rd_rx;
    logic       unused_bits;

    assign wr_tx   = pend & pend_wr & (pend_addr == 2'd0);
    assign wr_ctrl = pend & pend_wr & (pend_addr == 2'd3);
    assign rd_rx   = pend & ~pend_wr & (pend_addr == 2'd1);

    assign unused_bits = ^{bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0],
                           bus.HWDATA[31:8]};

    assign bus.HREADYOUT = 1'b1;
    assign CSn           = ~cs_en;

    always_comb begin
        bus.HRDATA = '0;
        unique case (pend_addr)
            2'd0: bus.HRDATA = '0;
            2'd1: bus.HRDATA = {24'd0, rxdata};
            2'd2: bus.HRDATA = {30'd0, rxvalid, busy};
            2'd3: bus.HRDATA = {31'd0, cs_en};
            default: bus.HRDATA = '0;
        endcase
    end

    // Address phase capture; data phase follows one cycle later.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend      <= 1'b0;
            pend_wr   <= 1'b0;
            pend_addr <= 2'd0;
        end else begin
            pend <= bus.HSEL & bus.HREADY & bus.HTRANS[1];
            if (bus.HSEL & bus.HREADY & bus.HTRANS[1]) begin
                pend_wr   <= bus.HWRITE;
                pend_addr <= bus.HADDR[3:2];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cs_en <= 1'b0;
        end else if (wr_ctrl) begin
            cs_en <= bus.HWDATA[0];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            bitcnt  <= 3'd0;
            shreg   <= 8'd0;
            rxdata  <= 8'd0;
            busy    <= 1'b0;
            rxvalid <= 1'b0;
            SCLK    <= 1'b0;
            MOSI    <= 1'b0;
        end else begin
            // A completing transfer below overrides this read-clear.
            if (rd_rx) begin
                rxvalid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (wr_tx) begin
                        shreg   <= bus.HWDATA[7:0];
                        MOSI    <= bus.HWDATA[7];
                        rxvalid <= 1'b0;
                        busy    <= 1'b1;
                        cnt     <= 8'd0;
                        bitcnt  <= 3'd0;
                        state   <= LOW;
                    end
                end
                LOW: begin
                    if (cnt == LAST) begin
                        cnt   <= 8'd0;
                        SCLK  <= 1'b1;
                        shreg <= {shreg[6:0], MISO};
                        state <= HIGH;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HIGH: begin
                    if (cnt == LAST) begin
                        cnt  <= 8'd0;
                        SCLK <= 1'b0;
                        if (bitcnt != 3'd7) begin
                            MOSI   <= shreg[7];
                            bitcnt <= bitcnt + 3'd1;
                            state  <= LOW;
                        end else begin
                            rxdata  <= shreg;
                            rxvalid <= 1'b1;
                            busy    <= 1'b0;
                            bitcnt  <= 3'd0;
                            state   <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
